// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA raster definitions.
//   - coord_t: 10-bit pixel/line coordinate used by the timing generator and
//     the framebuffer address mapper.
//   - Standard 640x480@60 Hz timing constants (active area, porches, sync,
//     totals, sync start/end positions).
//   - strobe_t: packed {hs, vs, von} strobe bundle carried by the delay line,
//     and its idle value (syncs deasserted high, video off).
package vga_pkg;

  typedef logic [9:0] coord_t;

  // Horizontal timing in pixels.
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  // Vertical timing in lines.
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Derived totals and sync windows (start inclusive, end exclusive).
  localparam int unsigned VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  typedef struct packed {
    logic hs;   // active-low horizontal sync
    logic vs;   // active-low vertical sync
    logic von;  // active-area flag
  } strobe_t;

  // Idle strobe value: both syncs released, video blanked.
  localparam strobe_t STROBE_IDLE = 3'b110;

  // Coordinate increment with the wrap decision left to the caller.
  function automatic coord_t coord_inc(input coord_t v);
    return v + coord_t'(1);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the timing generator to its
// consumers (framebuffer address mapper, DAC output stage).
//   pix_en      one-clk pixel tick
//   x_pixel     horizontal count
//   y_pixel     vertical count
//   hsync       active-low horizontal sync, delayed to match pixel data
//   vsync       active-low vertical sync, delayed to match pixel data
//   video_on    active-area flag, delayed to match pixel data
//   frame_start one-clk pulse after the counters wrap to (0,0), undelayed
//   frame_count 16-bit frame counter, present only when
//               VGA_TIMING_FRAME_COUNT_EN is defined
// Modports: master = generator side, slave = consumer side.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pix_en;
  coord_t x_pixel;
  coord_t y_pixel;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  modport master (
    output pix_en, x_pixel, y_pixel, hsync, vsync, video_on, frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , output frame_count
`endif
  );

  modport slave (
    input pix_en, x_pixel, y_pixel, hsync, vsync, video_on, frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , input frame_count
`endif
  );

endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register for the 3-bit {hs, vs, von}
// strobe bundle. Stages advance only when en is high and hold otherwise.
// Synchronous active-high reset loads every stage with the idle value 3'b110.
// DEPTH = 0 makes the line a plain wire from din to dout.
//   clk   system clock
//   rst   synchronous active-high reset
//   en    shift enable (pixel tick)
//   din   undelayed strobes
//   dout  strobes delayed by DEPTH enabled ticks
module sync_delay_line
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Clock, reset and enable have no function without stages.
      logic unused_bypass;
      assign unused_bypass = ^{clk, rst, en};
      assign dout = din;
    end else begin : g_pipe
      // tap[0] is the input, tap[k] is the output of stage k-1.
      logic [DEPTH:0][2:0] tap;
      assign tap[0] = din;

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [2:0] stage_q;
        logic [2:0] stage_d;

        always_comb begin
          stage_d = stage_q;
          if (en) begin
            stage_d = tap[gi];
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            stage_q <= STROBE_IDLE;
          end else begin
            stage_q <= stage_d;
          end
        end

        assign tap[gi+1] = stage_q;
      end

      assign dout = tap[DEPTH];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator (640x480@60 Hz by default,
// from a 50 MHz clock with CLK_DIV = 2).
//   clk  system clock
//   rst  synchronous active-high reset
//   vga  master side of vga_timing_gen_if:
//        pix_en, x_pixel, y_pixel, hsync, vsync, video_on, frame_start
//        (+ frame_count when VGA_TIMING_FRAME_COUNT_EN is defined)
// A free-running divider produces a registered one-clk pixel tick. The x/y
// counters advance on that tick. Sync and active-area strobes are decoded
// from the current counters and delayed by SYNC_DELAY pixel ticks so they
// line up with framebuffer read data arriving at the DAC. frame_start is not
// delayed.
// Optional feature macro: VGA_TIMING_FRAME_COUNT_EN adds a 16-bit wrapping
// frame counter that advances together with frame_start.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_END    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_END    = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_START = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_SYNC_START = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  // Divider counter is at least one bit wide so CLK_DIV = 1 still elaborates;
  // in that case it sits at 0 and every clk is a tick.
  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;
  coord_t           x_q, x_d;
  coord_t           y_q, y_d;
  logic             frame_start_q, frame_start_d;

  strobe_t          raw;
  logic [2:0]       dly_out;
  strobe_t          dly;

  // Divider and raster counters. pix_en is registered off the divider
  // terminal count, so counters step on the edge that sees pix_en_q high.
  always_comb begin
    div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    pix_en_d      = (div_cnt_q == DIV_LAST);
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;

    if (pix_en_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = coord_inc(y_q);
        end
      end else begin
        x_d = coord_inc(x_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Undelayed strobes decoded from the current counters.
  always_comb begin
    raw     = STROBE_IDLE;
    raw.hs  = ~((x_q >= H_SYNC_START) && (x_q < H_SYNC_END));
    raw.vs  = ~((y_q >= V_SYNC_START) && (y_q < V_SYNC_END));
    raw.von = (x_q < H_ACT_END) && (y_q < V_ACT_END);
  end

  sync_delay_line #(
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay_line (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en_q),
    .din  (raw),
    .dout (dly_out)
  );

  assign dly = strobe_t'(dly_out);

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Advances on the same edge that raises frame_start; wraps naturally.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign vga.frame_count = frame_count_q;
`endif

  assign vga.pix_en      = pix_en_q;
  assign vga.x_pixel     = x_q;
  assign vga.y_pixel     = y_q;
  assign vga.hsync       = dly.hs;
  assign vga.vsync       = dly.vs;
  assign vga.video_on    = dly.von;
  assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// dut0 uses the standard 640x480 timing with CLK_DIV=2, SYNC_DELAY=2 and
// covers reset, divider start-up, line timing, delay-line alignment and
// mid-frame reset. dut1 uses a shrunken raster (15x10, CLK_DIV=1,
// SYNC_DELAY=0) so whole frames fit in a short run: vsync window, frame
// wrap, frame_start pulses and the optional frame counter.
module tb_vga_timing_gen;

  logic clk;
  logic rst0;
  logic rst1;

  int checks   = 0;
  int failures = 0;
  int p0       = 0;   // dut0 pixel-tick position since last reset release
  int hs_lo0   = 0;
  int fs_cnt   = 0;
  int vs_lo    = 0;
  int hs_lo    = 0;
  int von_hi   = 0;

  vga_timing_gen_if vga0 ();
  vga_timing_gen_if vga1 ();

  vga_timing_gen #(
    .CLK_DIV    (2),
    .SYNC_DELAY (2)
  ) dut0 (
    .clk (clk),
    .rst (rst0),
    .vga (vga0)
  );

  vga_timing_gen #(
    .CLK_DIV    (1),
    .H_ACTIVE   (8),
    .H_FP       (2),
    .H_SYNC     (3),
    .H_BP       (2),
    .V_ACTIVE   (6),
    .V_FP       (1),
    .V_SYNC     (2),
    .V_BP       (1),
    .SYNC_DELAY (0)
  ) dut1 (
    .clk (clk),
    .rst (rst1),
    .vga (vga1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // dut0: each pixel tick is two clks (pix_en edge, then counter edge).
  task automatic adv_to(input int target);
    repeat (2 * (target - p0)) tick();
    p0 = target;
  endtask

  task automatic release0();
    rst0 = 1'b0;
    tick();
    chk("d0_pix_en_clk1", 32'(vga0.pix_en), 0);
    tick();
    chk("d0_pix_en_clk2", 32'(vga0.pix_en), 1);
    chk("d0_x_clk2", 32'(vga0.x_pixel), 0);
    tick();
    chk("d0_pix_en_clk3", 32'(vga0.pix_en), 0);
    chk("d0_x_first_tick", 32'(vga0.x_pixel), 1);
    chk("d0_von_p1", 32'(vga0.video_on), 0);
    p0 = 1;
  endtask

  task automatic pulse_rst0();
    rst0 = 1'b1;
    tick();
    chk("d0_rst_x", 32'(vga0.x_pixel), 0);
    chk("d0_rst_y", 32'(vga0.y_pixel), 0);
    chk("d0_rst_pix_en", 32'(vga0.pix_en), 0);
    chk("d0_rst_hsync", 32'(vga0.hsync), 1);
    chk("d0_rst_vsync", 32'(vga0.vsync), 1);
    chk("d0_rst_von", 32'(vga0.video_on), 0);
    chk("d0_rst_fs", 32'(vga0.frame_start), 0);
    p0 = 0;
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) tick();

    // Reset state.
    chk("d0_init_x", 32'(vga0.x_pixel), 0);
    chk("d0_init_y", 32'(vga0.y_pixel), 0);
    chk("d0_init_pix_en", 32'(vga0.pix_en), 0);
    chk("d0_init_hsync", 32'(vga0.hsync), 1);
    chk("d0_init_vsync", 32'(vga0.vsync), 1);
    chk("d0_init_von", 32'(vga0.video_on), 0);
    chk("d0_init_fs", 32'(vga0.frame_start), 0);
    chk("d1_init_pix_en", 32'(vga1.pix_en), 0);

    // Divider start-up and first tick.
    release0();

    // video_on rises two ticks after (0,0), falls two ticks after x=640.
    adv_to(2);
    chk("d0_von_rise", 32'(vga0.video_on), 1);
    adv_to(641);
    chk("d0_von_before_fall", 32'(vga0.video_on), 1);
    adv_to(642);
    chk("d0_von_fall", 32'(vga0.video_on), 0);

    // hsync low for raw x=656..751, seen two ticks later.
    adv_to(657);
    chk("d0_hs_before", 32'(vga0.hsync), 1);
    adv_to(658);
    chk("d0_hs_first_low", 32'(vga0.hsync), 0);
    adv_to(753);
    chk("d0_hs_last_low", 32'(vga0.hsync), 0);
    adv_to(754);
    chk("d0_hs_release", 32'(vga0.hsync), 1);

    // Line wrap: x 799->0 and y 0->1 on the same tick.
    adv_to(799);
    chk("d0_x_799", 32'(vga0.x_pixel), 799);
    chk("d0_y_0", 32'(vga0.y_pixel), 0);
    adv_to(800);
    chk("d0_x_wrap", 32'(vga0.x_pixel), 0);
    chk("d0_y_inc", 32'(vga0.y_pixel), 1);
    adv_to(801);
    chk("d0_von_blank_eol", 32'(vga0.video_on), 0);
    adv_to(802);
    chk("d0_von_line1", 32'(vga0.video_on), 1);

    // hsync low count across one full line.
    for (int k = 803; k <= 1602; k++) begin
      adv_to(k);
      if (!vga0.hsync) hs_lo0++;
    end
    chk("d0_hs_low_ticks", 32'(hs_lo0), 96);
    chk("d0_vsync_idle", 32'(vga0.vsync), 1);

    // Mid-frame reset at x=300,y=2 with video_on high.
    adv_to(1900);
    chk("d0_x_300", 32'(vga0.x_pixel), 300);
    chk("d0_y_2", 32'(vga0.y_pixel), 2);
    chk("d0_von_pre_rst", 32'(vga0.video_on), 1);
    pulse_rst0();
    release0();

    // Mid-line reset while hsync is low.
    adv_to(1500);
    chk("d0_x_700", 32'(vga0.x_pixel), 700);
    chk("d0_hs_pre_rst", 32'(vga0.hsync), 0);
    pulse_rst0();
    release0();

    // dut1: 15x10 raster, one clk per pixel, undelayed strobes.
    rst1 = 1'b0;
    tick();
    chk("d1_pix_en_clk1", 32'(vga1.pix_en), 1);
    chk("d1_x0", 32'(vga1.x_pixel), 0);
    chk("d1_von0", 32'(vga1.video_on), 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("d1_fc_init", 32'(vga1.frame_count), 0);
`endif
    for (int q = 1; q <= 450; q++) begin
      tick();
      if (vga1.frame_start) fs_cnt++;
      if (!vga1.vsync) vs_lo++;
      if (!vga1.hsync) hs_lo++;
      if (vga1.video_on) von_hi++;
      if (q == 104) chk("d1_vs_before", 32'(vga1.vsync), 1);
      if (q == 105) begin
        chk("d1_vs_first_low", 32'(vga1.vsync), 0);
        chk("d1_y7", 32'(vga1.y_pixel), 7);
      end
      if (q == 134) chk("d1_vs_last_low", 32'(vga1.vsync), 0);
      if (q == 135) chk("d1_vs_release", 32'(vga1.vsync), 1);
      if (q == 149) begin
        chk("d1_x_last", 32'(vga1.x_pixel), 14);
        chk("d1_y_last", 32'(vga1.y_pixel), 9);
        chk("d1_fs_before", 32'(vga1.frame_start), 0);
      end
      if (q == 150) begin
        chk("d1_x_wrap", 32'(vga1.x_pixel), 0);
        chk("d1_y_wrap", 32'(vga1.y_pixel), 0);
        chk("d1_fs_pulse", 32'(vga1.frame_start), 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        chk("d1_fc_1", 32'(vga1.frame_count), 1);
`endif
      end
      if (q == 151) chk("d1_fs_single", 32'(vga1.frame_start), 0);
    end
    chk("d1_fs_count", 32'(fs_cnt), 3);
    chk("d1_vs_low_ticks", 32'(vs_lo), 90);
    chk("d1_hs_low_ticks", 32'(hs_lo), 90);
    chk("d1_von_ticks", 32'(von_hi), 144);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("d1_fc_3", 32'(vga1.frame_count), 3);
`endif

    // dut1 reset while hsync is low at x=10.
    repeat (10) tick();
    chk("d1_hs_pre_rst", 32'(vga1.hsync), 0);
    rst1 = 1'b1;
    tick();
    chk("d1_rst_x", 32'(vga1.x_pixel), 0);
    chk("d1_rst_y", 32'(vga1.y_pixel), 0);
    chk("d1_rst_hsync", 32'(vga1.hsync), 1);
    chk("d1_rst_pix_en", 32'(vga1.pix_en), 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("d1_rst_fc", 32'(vga1.frame_count), 0);
`endif
    rst1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
